// File: rtl/serializer_pkg.sv
// Shared types and helpers for the parametrised serializer.
package serializer_pkg;

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    // A length field of zero encodes a full-width word.
    function automatic int unsigned eff_len(input int unsigned mod, input int unsigned data_w);
        return (mod == 0) ? data_w : mod;
    endfunction

    // Non-zero lengths shorter than min_len are dropped on input.
    function automatic logic is_legal(input int unsigned mod, input int unsigned min_len);
        return (mod == 0) || (mod >= min_len);
    endfunction

endpackage

// File: rtl/ser_word_buf.sv
// One-entry holding register for a word waiting behind the active one.
module ser_word_buf #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned MOD_W  = 4
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  mod_i,
    input  logic              lsb_first_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [MOD_W-1:0]  mod_o,
    output logic              lsb_first_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [MOD_W-1:0]  mod_q, mod_d;
    logic              lsb_q, lsb_d;

    // Push only happens while empty and pop only while full, so they never collide.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        mod_d   = mod_q;
        lsb_d   = lsb_q;
        if (push_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            mod_d   = mod_i;
            lsb_d   = lsb_first_i;
        end else if (pop_i) begin
            valid_d = 1'b0;
        end
    end

    // Buffer state register.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            mod_q   <= '0;
            lsb_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            mod_q   <= mod_d;
            lsb_q   <= lsb_d;
        end
    end

    assign valid_o     = valid_q;
    assign data_o      = data_q;
    assign mod_o       = mod_q;
    assign lsb_first_o = lsb_q;

endmodule

// File: rtl/serializer_param.sv
// Parallel-to-serial converter with per-word length and bit order, and a
// one-word holding buffer so consecutive words stream with no gap.
module serializer_param
    import serializer_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MOD_W   = $clog2(DATA_W),
    parameter int unsigned MIN_LEN = 3
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    input  logic              data_lsb_first_i,
    input  logic              data_val_i,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
    output logic              busy_o
);

    function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < int'(DATA_W); i++) begin
            r[i] = d[DATA_W-1-i];
        end
        return r;
    endfunction

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [MOD_W-1:0]  cnt_q, cnt_d;
    logic              ser_data_q, ser_data_d;
    logic              ser_val_q, ser_val_d;

    logic              buf_valid, buf_push, buf_pop, buf_lsb;
    logic [DATA_W-1:0] buf_data;
    logic [MOD_W-1:0]  buf_mod;

    logic              in_take;
    logic              ld_en, ld_lsb;
    logic [DATA_W-1:0] ld_data, ld_norm;
    logic [MOD_W-1:0]  ld_mod;

    // Accepted and legal; illegal short words are swallowed with no effect.
    assign in_take = data_val_i & ~buf_valid & is_legal(32'(data_mod_i), MIN_LEN);

    // Next-state: cnt_q counts the bits still to come after the one on ser_data_o.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        ser_data_d = ser_data_q;
        ser_val_d  = ser_val_q;
        buf_push   = 1'b0;
        buf_pop    = 1'b0;
        ld_en      = 1'b0;
        ld_data    = data_i;
        ld_mod     = data_mod_i;
        ld_lsb     = data_lsb_first_i;
        ld_norm    = '0;

        unique case (state_q)
            StIdle: begin
                if (in_take) begin
                    ld_en   = 1'b1;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (cnt_q != '0) begin
                    ser_data_d = shift_q[DATA_W-1];
                    shift_d    = shift_q << 1;
                    cnt_d      = cnt_q - 1'b1;
                    buf_push   = in_take;
                end else if (buf_valid) begin
                    buf_pop = 1'b1;
                    ld_en   = 1'b1;
                    ld_data = buf_data;
                    ld_mod  = buf_mod;
                    ld_lsb  = buf_lsb;
                end else if (in_take) begin
                    ld_en = 1'b1;
                end else begin
                    state_d    = StIdle;
                    ser_val_d  = 1'b0;
                    ser_data_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Words are normalised to MSB-first so the shifter only ever moves left.
        if (ld_en) begin
            ld_norm    = ld_lsb ? bit_rev(ld_data) : ld_data;
            ser_data_d = ld_norm[DATA_W-1];
            ser_val_d  = 1'b1;
            shift_d    = ld_norm << 1;
            cnt_d      = MOD_W'(eff_len(32'(ld_mod), DATA_W) - 1);
        end
    end

    // State, shifter, counter and registered outputs.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            cnt_q      <= '0;
            ser_data_q <= 1'b0;
            ser_val_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            ser_data_q <= ser_data_d;
            ser_val_q  <= ser_val_d;
        end
    end

    ser_word_buf #(
        .DATA_W (DATA_W),
        .MOD_W  (MOD_W)
    ) u_buf (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .push_i      (buf_push),
        .pop_i       (buf_pop),
        .data_i      (data_i),
        .mod_i       (data_mod_i),
        .lsb_first_i (data_lsb_first_i),
        .valid_o     (buf_valid),
        .data_o      (buf_data),
        .mod_o       (buf_mod),
        .lsb_first_o (buf_lsb)
    );

    assign ser_data_o     = ser_data_q;
    assign ser_data_val_o = ser_val_q;
    assign busy_o         = buf_valid;

endmodule

// File: tb/tb_serializer_param.sv
// Self-checking bench for serializer_param: directed cases plus random traffic
// against a queue-based reference model.
module tb_serializer_param;

    localparam int DW = 16;
    localparam int MW = 4;
    localparam int ML = 3;

    logic          clk_i = 1'b0;
    logic          arst_i;
    logic [DW-1:0] data_i;
    logic [MW-1:0] data_mod_i;
    logic          data_lsb_first_i;
    logic          data_val_i;
    logic          ser_data_o;
    logic          ser_data_val_o;
    logic          busy_o;

    serializer_param #(
        .DATA_W  (DW),
        .MOD_W   (MW),
        .MIN_LEN (ML)
    ) dut (
        .clk_i            (clk_i),
        .arst_i           (arst_i),
        .data_i           (data_i),
        .data_mod_i       (data_mod_i),
        .data_lsb_first_i (data_lsb_first_i),
        .data_val_i       (data_val_i),
        .ser_data_o       (ser_data_o),
        .ser_data_val_o   (ser_data_val_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: bits still to appear on the line (head = bit now shown)
    // and the word parked in the holding buffer.
    bit q_out[$];
    bit buf_bits[$];
    bit buf_full = 1'b0;

    bit            cap_en = 1'b0;
    logic [DW-1:0] cap;
    int            cap_n;

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit v, input logic [DW-1:0] d, input int m, input bit l);
        bit acc, legal;
        int len;
        bit w[$];
        acc   = v && !buf_full;
        legal = (m == 0) || (m >= ML);
        len   = (m == 0) ? DW : m;
        for (int i = 0; i < len; i++) w.push_back(l ? d[i] : d[DW-1-i]);
        if (q_out.size() > 0) void'(q_out.pop_front());
        if (q_out.size() == 0) begin
            if (buf_full) begin
                q_out    = buf_bits;
                buf_full = 1'b0;
            end else if (acc && legal) begin
                q_out = w;
            end
        end else if (acc && legal) begin
            buf_bits = w;
            buf_full = 1'b1;
        end
    endtask

    task automatic step(input bit v, input logic [DW-1:0] d, input logic [MW-1:0] m,
                        input bit l);
        data_val_i       = v;
        data_i           = d;
        data_mod_i       = m;
        data_lsb_first_i = l;
        @(posedge clk_i);
        model_edge(v, d, int'(m), l);
        #1;
        check1("ser_val", ser_data_val_o, q_out.size() > 0);
        check1("ser_data", ser_data_o, (q_out.size() > 0) ? q_out[0] : 1'b0);
        check1("busy", busy_o, buf_full);
        if (cap_en && ser_data_val_o === 1'b1) begin
            cap = {cap[DW-2:0], ser_data_o};
            cap_n++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0);
    endtask

    task automatic cap_start();
        cap_en = 1'b1;
        cap    = '0;
        cap_n  = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        arst_i = 1'b1;
        data_val_i = 1'b0; data_i = '0; data_mod_i = '0; data_lsb_first_i = 1'b0;
        #2;
        check1("rst_ser_val", ser_data_val_o, 1'b0);
        check1("rst_ser_data", ser_data_o, 1'b0);
        check1("rst_busy", busy_o, 1'b0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        arst_i = 1'b0;
        idle(2);

        // Full-width MSB first
        cap_start();
        step(1'b1, 16'hA5C3, 4'd0, 1'b0);
        idle(17);
        cap_en = 1'b0;
        check32("full_bits", 32'(cap), 32'h0000A5C3);
        check32("full_len", 32'(cap_n), 32'd16);

        // Short words, both orders
        cap_start();
        step(1'b1, 16'hF800, 4'd5, 1'b0);
        idle(6);
        cap_en = 1'b0;
        check32("short_msb", 32'(cap), 32'h1F);
        cap_start();
        step(1'b1, 16'h0013, 4'd5, 1'b1);
        idle(6);
        cap_en = 1'b0;
        check32("short_lsb", 32'(cap), 32'h19);

        // Illegal lengths, then a minimum-length word
        step(1'b1, 16'hFFFF, 4'd1, 1'b0);
        idle(1);
        step(1'b1, 16'hFFFF, 4'd2, 1'b1);
        idle(2);
        cap_start();
        step(1'b1, 16'hA000, 4'd3, 1'b0);
        idle(4);
        cap_en = 1'b0;
        check32("min_len_bits", 32'(cap), 32'h5);
        check32("min_len_cnt", 32'(cap_n), 32'd3);

        // Back-to-back through the buffer; C is dropped while busy
        cap_start();
        step(1'b1, 16'hB000, 4'd4, 1'b0);
        step(1'b1, 16'h0005, 4'd3, 1'b1);
        step(1'b1, 16'hFFFF, 4'd5, 1'b0);
        idle(6);
        cap_en = 1'b0;
        check32("b2b_bits", 32'(cap), 32'h5D);
        check32("b2b_cnt", 32'(cap_n), 32'd7);

        // Back-to-back via direct load on the last bit
        cap_start();
        step(1'b1, 16'h9000, 4'd4, 1'b0);
        idle(3);
        step(1'b1, 16'h0006, 4'd3, 1'b1);
        idle(4);
        cap_en = 1'b0;
        check32("direct_bits", 32'(cap), 32'h4B);
        check32("direct_cnt", 32'(cap_n), 32'd7);

        // Reset mid-word with the buffer full
        step(1'b1, 16'h7FFE, 4'd0, 1'b0);
        step(1'b1, 16'hFFFF, 4'd0, 1'b1);
        idle(4);
        #2;
        arst_i = 1'b1;
        #1;
        check1("amid_ser_val", ser_data_val_o, 1'b0);
        check1("amid_ser_data", ser_data_o, 1'b0);
        check1("amid_busy", busy_o, 1'b0);
        q_out.delete();
        buf_bits.delete();
        buf_full = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        arst_i = 1'b0;
        idle(1);
        cap_start();
        step(1'b1, 16'h8001, 4'd0, 1'b0);
        idle(17);
        cap_en = 1'b0;
        check32("post_rst_bits", 32'(cap), 32'h8001);
        check32("post_rst_cnt", 32'(cap_n), 32'd16);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 2) == 0), DW'($urandom), MW'($urandom_range(0, 15)),
                 1'($urandom));
        end
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serializer_param.md
# serializer_param

Parametrised serializer that converts a parallel word of programmable valid length into a one-bit stream with a qualifying strobe. Successor to the fixed 16-bit serializer: width is a parameter, bit order is selected per word, and a one-word holding buffer allows back-to-back words with no idle cycle between them. Sits between parallel datapath logic and bit-serial link or PHY logic; its outputs are registered, so it can drive the top-level I/O register stage directly.

## Interface
- DATA_W, 16: parallel word width; power of two, ≥ 4.
- MOD_W, $clog2(DATA_W): width of the length field.
- MIN_LEN, 3: smallest legal non-zero length; non-zero lengths below this value are dropped.

Ports (one clock; reset is asynchronous and active-high):
- clk_i  in  1  clock.
- arst_i  in  1  asynchronous, active-high reset.
- data_i  in  DATA_W  parallel word.
- data_mod_i  in  MOD_W  number of valid bits; 0 means DATA_W.
- data_lsb_first_i  in  1  bit order for this word: 0 = MSB first, 1 = LSB first.
- data_val_i  in  1  word strobe.
- ser_data_o  out  1  serial bit; 0 when ser_data_val_o = 0.
- ser_data_val_o  out  1  serial bit valid.
- busy_o  out  1  holding buffer full; input words are not accepted.

## Operation
- Acceptance: a word is accepted when data_val_i = 1 and busy_o = 0. A word presented while busy_o = 1 is ignored; there is no backpressure beyond busy_o.
- Effective length: len = DATA_W if data_mod_i = 0, else data_mod_i.
  - A word with 0 < data_mod_i < MIN_LEN is accepted and discarded: no output, no state change.
- Bit selection:
  - MSB first: bits data_i[DATA_W-1] down to data_i[DATA_W-len].
  - LSB first: bits data_i[0] up to data_i[len-1].
  - Unselected bits are don't-care.
- FSM, two states:
  - IDLE: an accepted legal word loads the shifter and the bit counter (len-1). Next state is SHIFT.
  - SHIFT: one bit is driven per cycle and the counter decrements.
  - On the last bit (counter = 0):
    - If the holding buffer is full, its word loads into the shifter in the same cycle, the buffer clears, and the FSM stays in SHIFT.
    - Else, if a legal word is accepted that cycle, it loads directly into the shifter and the FSM stays in SHIFT.
    - Otherwise the FSM returns to IDLE.
  - A legal word accepted in SHIFT that is not on the last-bit load path goes to the holding buffer.
- busy_o equals the holding-buffer valid flag.
- Reset (asynchronous, any time): the FSM goes to IDLE, the buffer is emptied, and ser_data_o, ser_data_val_o and busy_o are forced to 0 immediately. A word in flight is lost. Operation resumes on the first clock edge after deassertion.

## Timing
- Latency: a word accepted at cycle N, with the shifter idle, drives its first bit at N+1. ser_data_val_o is high for exactly len consecutive cycles.
- Back-to-back: a word taken from the holding buffer starts on the cycle immediately after the previous word's last bit. There are no gap cycles.
- busy_o rises the cycle after a word enters the buffer. It falls the cycle after the buffer drains into the shifter.
- All outputs are flops; no combinational path from any input to any output.

## Structure
- Package serializer_pkg contains:
  - state enum {IDLE, SHIFT};
  - function eff_len(mod, DATA_W) returning the effective length;
  - function is_legal(mod, MIN_LEN).
- Sub-module ser_word_buf: one-entry holding register storing data, length and order, with a valid flag and a pop strobe. The top level contains the FSM, shifter and counter.

## Test plan
Default parameters apply unless stated.
- Full-width MSB first: data_i = 16'hA5C3, mod 0, MSB first, accepted at N.
  - Required: bits 1010_0101_1100_0011 on cycles N+1..N+16, ser_data_val_o high for exactly 16 cycles, busy_o stays 0.
- Short words, both orders:
  - 16'hF800, mod 5, MSB first → bits 1,1,1,1,1 (5 cycles).
  - 16'h0013, mod 5, LSB first → bits 1,1,0,0,1.
- Illegal lengths: words with mod 1 and mod 2 → ser_data_val_o and busy_o stay 0. A following word with mod 3 serializes normally.
- Back-to-back with a dropped word: word A (mod 4) at N, word B (mod 3) at N+1, word C (mod 5) at N+2.
  - ser_data_val_o is continuous on N+1..N+7: A on N+1..N+4, B on N+5..N+7.
  - busy_o is high on N+2..N+4.
  - C is dropped.
- Back-to-back via direct load: word D (mod 3) accepted at N+4 (last bit of A, buffer empty) → D bits on N+5..N+7 with no gap.
- Reset mid-word: arst_i asserted during bit 6 of a 16-bit word, with the buffer full.
  - All outputs go to 0 immediately.
  - After release, a new word 16'h8001 with mod 0 serializes with no residue of the old word.
